// File: rtl/cgra_arb_pkg.sv
// Shared definitions for CGRA processing-element arbiters.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
//
// Contents: arbiter state enum, default port/burst constants and the
// PORT_ID_W() helper that sizes port-index fields (never narrower than 1 bit).
package cgra_arb_pkg;

    localparam int DEF_NUM_PORTS = 4;
    localparam int DEF_BURST_LEN = 4;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    function automatic int PORT_ID_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set req bit searching upward from last+1.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides whether the winner is actually served.
//
// Ports:
//   req    : request vector, one bit per requester
//   last   : index of the previously served requester (must be < N)
//   winner : index of the selected requester (0 when any is low)
//   any    : at least one request is set
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [IDW-1:0] winner,
    output logic           any
);

    logic [IDW-1:0] idx;

    // Walk the ring starting one past 'last'; 'last' itself is checked
    // last so a lone requester can win back-to-back.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = last;
        for (int i = 0; i < N; i++) begin
            idx = (idx == IDW'(N - 1)) ? '0 : idx + IDW'(1);
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/d_fifo_rr_arbiter.sv
// Round-robin merge of NUM_PORTS valid/ready producers onto one FIFO write port,
// holding a grant for up to BURST_LEN beats. Latency: 1 cycle (registered dout).
// Backpressure: din_r only asserts when the output register is empty or draining.
//
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   din / din_v/din_r : packed producer payloads (port i at [i*DATA_WIDTH +: DATA_WIDTH]),
//                       per-port valid, one-hot-or-zero combinational ready
//   dout/dout_v/dout_r: registered payload/valid toward the FIFO, FIFO ready
//   dout_id           : registered source port of the beat on dout
//   grant_cnt         : per-port 16-bit accepted-beat counters, only when
//                       D_FIFO_ARB_STATS_EN is defined
module d_fifo_rr_arbiter
    import cgra_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] din,
    input  logic [NUM_PORTS-1:0]            din_v,
    output logic [NUM_PORTS-1:0]            din_r,
    output logic [DATA_WIDTH-1:0]           dout,
    output logic                            dout_v,
    input  logic                            dout_r,
    output logic [PORT_ID_W(NUM_PORTS)-1:0] dout_id
`ifdef D_FIFO_ARB_STATS_EN
    ,
    output logic [NUM_PORTS*16-1:0]         grant_cnt
`endif
);

    localparam int IDW   = PORT_ID_W(NUM_PORTS);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    arb_state_e      state_q, state_d;
    logic [IDW-1:0]  last_grant_q, last_grant_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic [IDW-1:0]        dout_id_q, dout_id_d;
    logic                  dout_v_q, dout_v_d;

    logic [IDW-1:0] win;
    logic           any_req;
    logic           can_acc;
    logic           cap;
    logic [IDW-1:0] sel;

    rr_pick #(
        .N   (NUM_PORTS),
        .IDW (IDW)
    ) u_pick (
        .req    (din_v),
        .last   (last_grant_q),
        .winner (win),
        .any    (any_req)
    );

    // Output register can take a new beat if it is empty or being drained now.
    assign can_acc = ~dout_v_q | dout_r;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        beat_cnt_d   = beat_cnt_q;
        cnt_inc      = beat_cnt_q + CNT_W'(1);
        cap          = 1'b0;
        sel          = win;

        case (state_q)
            IDLE: begin
                if (any_req && can_acc && !reset) begin
                    cap          = 1'b1;
                    last_grant_d = win;
                    owner_d      = win;
                    beat_cnt_d   = CNT_W'(1);
                    state_d      = (BURST_LEN > 1) ? LOCK : IDLE;
                end
            end
            LOCK: begin
                sel = owner_q;
                if (!din_v[owner_q]) begin
                    // Owner went quiet: release the lock, others get a turn
                    // from IDLE on the following cycle.
                    state_d = IDLE;
                end else if (can_acc && !reset) begin
                    cap        = 1'b1;
                    beat_cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(BURST_LEN)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        din_r = '0;
        if (cap) begin
            din_r[sel] = 1'b1;
        end
    end

    // A capture always overwrites the register, even when the old beat is
    // leaving this same cycle, so dout_v stays high across back-to-back beats.
    always_comb begin
        dout_d    = dout_q;
        dout_id_d = dout_id_q;
        dout_v_d  = dout_v_q;
        if (cap) begin
            dout_d    = din[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
            dout_id_d = sel;
            dout_v_d  = 1'b1;
        end else if (dout_r) begin
            dout_v_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NUM_PORTS - 1);
            owner_q      <= '0;
            beat_cnt_q   <= '0;
            dout_q       <= '0;
            dout_id_q    <= '0;
            dout_v_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            beat_cnt_q   <= beat_cnt_d;
            dout_q       <= dout_d;
            dout_id_q    <= dout_id_d;
            dout_v_q     <= dout_v_d;
        end
    end

    assign dout    = dout_q;
    assign dout_id = dout_id_q;
    assign dout_v  = dout_v_q;

`ifdef D_FIFO_ARB_STATS_EN
    logic [NUM_PORTS*16-1:0] grant_cnt_q, grant_cnt_d;

    // Counters wrap naturally at 16 bits.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (cap && (sel == IDW'(i))) begin
                grant_cnt_d[i*16 +: 16] = grant_cnt_q[i*16 +: 16] + 16'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_d_fifo_rr_arbiter.sv
// Self-checking bench for d_fifo_rr_arbiter: table of per-cycle vectors with
// a beat scoreboard, plus hand sequences for BURST_LEN=1 and the stats counters.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_d_fifo_rr_arbiter;

    localparam int DW = 32;
    localparam int NP = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Main DUT, BURST_LEN = 4
    logic              reset;
    logic [NP*DW-1:0]  din;
    logic [NP-1:0]     din_v;
    logic [NP-1:0]     din_r;
    logic [DW-1:0]     dout;
    logic              dout_v;
    logic              dout_r;
    logic [1:0]        dout_id;

    // Second DUT, BURST_LEN = 1
    logic              b1_reset;
    logic [NP-1:0]     b1_din_v;
    logic [NP-1:0]     b1_din_r;
    logic [DW-1:0]     b1_dout;
    logic              b1_dout_v;
    logic              b1_dout_r;
    logic [1:0]        b1_dout_id;

`ifdef D_FIFO_ARB_STATS_EN
    logic [NP*16-1:0]  grant_cnt;
    logic [NP*16-1:0]  b1_grant_cnt;
`endif

    d_fifo_rr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_PORTS  (NP),
        .BURST_LEN  (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .din       (din),
        .din_v     (din_v),
        .din_r     (din_r),
        .dout      (dout),
        .dout_v    (dout_v),
        .dout_r    (dout_r),
        .dout_id   (dout_id)
`ifdef D_FIFO_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    d_fifo_rr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_PORTS  (NP),
        .BURST_LEN  (1)
    ) dut_b1 (
        .clock     (clock),
        .reset     (b1_reset),
        .din       (din),
        .din_v     (b1_din_v),
        .din_r     (b1_din_r),
        .dout      (b1_dout),
        .dout_v    (b1_dout_v),
        .dout_r    (b1_dout_r),
        .dout_id   (b1_dout_id)
`ifdef D_FIFO_ARB_STATS_EN
        ,
        .grant_cnt (b1_grant_cnt)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic       rst;
        logic [3:0] v;
        logic       rdy;
        logic [3:0] exp_rdy;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic [3:0] v,
                                input logic rdy, input logic [3:0] e);
        vec_t t;
        t.rst     = rst;
        t.v       = v;
        t.rdy     = rdy;
        t.exp_rdy = e;
        return t;
    endfunction

    vec_t tbl[$];
    int   exp_q[$];     // expected source port of each beat, in output order
    vec_t r;
    int   cap_id;
    int   got_id;
    int   last_id;
    logic dv_exp;

    // Watchdog: the whole run is a few hundred cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NP; i++) din[i*DW +: DW] = 32'h10 + 32'(i);
        reset     = 1'b1;
        din_v     = '0;
        dout_r    = 1'b0;
        b1_reset  = 1'b1;
        b1_din_v  = '0;
        b1_dout_r = 1'b0;

        // ---------------- vector table ----------------
        // Reset, including valid inputs that must not see any ready.
        tbl.push_back(mk(1'b1, 4'h0, 1'b0, 4'h0));
        tbl.push_back(mk(1'b1, 4'hF, 1'b1, 4'h0));
        // All ports valid: 4-beat bursts 0,1,2,3. The IDLE cycle after a
        // burst carries the first beat of the next owner.
        for (int p = 0; p < NP; p++)
            for (int b = 0; b < 4; b++)
                tbl.push_back(mk(1'b0, 4'hF, 1'b1, 4'(1 << p)));
        // Port 2 alone for 3 beats, drops; port 3 is then granted from IDLE.
        for (int b = 0; b < 3; b++) tbl.push_back(mk(1'b0, 4'h4, 1'b1, 4'h4));
        tbl.push_back(mk(1'b0, 4'h8, 1'b1, 4'h0));
        tbl.push_back(mk(1'b0, 4'h8, 1'b1, 4'h8));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1, 4'h0));
        // dout_r low for 5 cycles with port 1 valid: one capture, then held.
        tbl.push_back(mk(1'b0, 4'h2, 1'b0, 4'h2));
        for (int b = 0; b < 4; b++) tbl.push_back(mk(1'b0, 4'h2, 1'b0, 4'h0));
        tbl.push_back(mk(1'b0, 4'h2, 1'b1, 4'h2));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1, 4'h0));
        // Port 1 burst, reset on its second beat; port 0 wins afterwards.
        tbl.push_back(mk(1'b0, 4'h2, 1'b1, 4'h2));
        tbl.push_back(mk(1'b1, 4'hF, 1'b1, 4'h0));
        for (int b = 0; b < 4; b++) tbl.push_back(mk(1'b0, 4'hF, 1'b1, 4'h1));
        tbl.push_back(mk(1'b0, 4'hF, 1'b1, 4'h2));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1, 4'h0));
        tbl.push_back(mk(1'b0, 4'h0, 1'b1, 4'h0));

        dv_exp  = 1'b0;
        last_id = 0;
        for (int n = 0; n < tbl.size(); n++) begin
            r      = tbl[n];
            reset  = r.rst;
            din_v  = r.v;
            dout_r = r.rdy;
            #1;
            check($sformatf("din_r row %0d", n), 64'(din_r), 64'(r.exp_rdy));

            // Scoreboard: a beat leaves when dout_v & dout_r at this edge.
            if (!r.rst && dout_v && dout_r) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("sb_underflow row %0d", n), 64'(dout_id), 64'hFFFF);
                end else begin
                    got_id = exp_q.pop_front();
                    check($sformatf("sb_id row %0d", n), 64'(dout_id), 64'(got_id));
                    check($sformatf("sb_dat row %0d", n), 64'(dout), 64'(32'h10 + 32'(got_id)));
                end
            end

            cap_id = -1;
            for (int k = 0; k < NP; k++) if (r.exp_rdy[k]) cap_id = k;
            if (r.rst) exp_q.delete();
            else if (cap_id >= 0) exp_q.push_back(cap_id);

            @(posedge clock);
            #1;
            if (r.rst) begin
                dv_exp  = 1'b0;
                last_id = 0;
            end else if (cap_id >= 0) begin
                dv_exp  = 1'b1;
                last_id = cap_id;
            end else if (r.rdy) begin
                dv_exp  = 1'b0;
            end
            check($sformatf("dout_v row %0d", n), 64'(dout_v), 64'(dv_exp));
            if (r.rst) begin
                check($sformatf("rst_dout row %0d", n), 64'(dout), 64'h0);
                check($sformatf("rst_dout_id row %0d", n), 64'(dout_id), 64'h0);
            end else if (dv_exp) begin
                check($sformatf("dout_id row %0d", n), 64'(dout_id), 64'(last_id));
                check($sformatf("dout row %0d", n), 64'(dout), 64'(32'h10 + 32'(last_id)));
            end
        end
        check("sb_empty", 64'(exp_q.size()), 64'h0);

        // ---------------- BURST_LEN = 1: ports 0 and 3 alternate ----------------
        @(posedge clock);
        #1;
        b1_reset = 1'b0;
        b1_din_v = 4'b1001;
        b1_dout_r = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("b1_din_r cyc %0d", c), 64'(b1_din_r),
                  (c % 2 == 0) ? 64'h1 : 64'h8);
            @(posedge clock);
            #1;
            check($sformatf("b1_dout_v cyc %0d", c), 64'(b1_dout_v), 64'h1);
            check($sformatf("b1_dout_id cyc %0d", c), 64'(b1_dout_id),
                  (c % 2 == 0) ? 64'h0 : 64'h3);
            check($sformatf("b1_dout cyc %0d", c), 64'(b1_dout),
                  (c % 2 == 0) ? 64'h10 : 64'h13);
        end
        b1_din_v = '0;

`ifdef D_FIFO_ARB_STATS_EN
        // ---------------- stats: 10 beats from port 3 ----------------
        reset  = 1'b1;
        din_v  = '0;
        dout_r = 1'b1;
        @(posedge clock);
        #1;
        check("stats_reset", 64'(grant_cnt), 64'h0);
        reset = 1'b0;
        din_v = 4'h8;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #1;
        end
        din_v = '0;
        @(posedge clock);
        #1;
        check("grant_cnt port3", 64'(grant_cnt[63:48]), 64'd10);
        check("grant_cnt port0-2", 64'(grant_cnt[47:0]), 64'h0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
